// File: rtl/time_counter.sv
// time_counter: BCD HH:MM:SS clock with 1 Hz prescaler and set mode; TWELVE_HOUR_EN selects 12-hour display with pm flag
module time_counter #(
  parameter int DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_mode,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        clr_sec,
  output logic [15:0] currenttime,
  output logic [7:0]  hours,
  output logic        pm,
  output logic        sec_tick,
  output logic        on_hour
);
`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] HR_TOP = 8'h12, HR_WRAP = 8'h01, HR_RST = 8'h12;
  localparam logic TWELVE = 1'b1;
`else
  localparam logic [7:0] HR_TOP = 8'h23, HR_WRAP = 8'h00, HR_RST = 8'h00;
  localparam logic TWELVE = 1'b0;
`endif
  localparam int CW = $clog2(DIV);
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top, input logic [7:0] wrap);
    return (v == top) ? wrap : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  logic [CW-1:0] cnt;
  logic          tick, sec_wrap, min_wrap, pm_flip;
  logic [7:0]    hr_inc;
  assign tick     = !set_mode && cnt == CW'(DIV - 1);
  assign sec_wrap = currenttime[7:0] == 8'h59;
  assign min_wrap = currenttime[15:8] == 8'h59;
  assign hr_inc   = bcd_inc(hours, HR_TOP, HR_WRAP);
  assign pm_flip  = TWELVE && hours == 8'h11;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      currenttime <= 16'h0000;
      hours       <= HR_RST;
      pm          <= 1'b0;
      sec_tick    <= 1'b0;
      on_hour     <= 1'b0;
    end else begin
      cnt      <= (set_mode || tick) ? '0 : cnt + CW'(1);
      sec_tick <= tick;
      on_hour  <= tick && sec_wrap && min_wrap;
      if (tick) begin
        currenttime[7:0] <= bcd_inc(currenttime[7:0], 8'h59, 8'h00);
        if (sec_wrap) currenttime[15:8] <= bcd_inc(currenttime[15:8], 8'h59, 8'h00);
        if (sec_wrap && min_wrap) begin
          hours <= hr_inc;
          pm    <= pm ^ pm_flip;
        end
      end else if (set_mode) begin
        if (inc_min) currenttime[15:8] <= bcd_inc(currenttime[15:8], 8'h59, 8'h00);
        if (clr_sec) currenttime[7:0] <= 8'h00;
        if (inc_hour) begin
          hours <= hr_inc;
          pm    <= pm ^ pm_flip;
        end
      end
    end
  end
endmodule
